// File: rtl/core_apb_arbiter.sv
// rtl/core_apb_arbiter.sv - round-robin N-to-1 APB arbiter; optional ACCESS watchdog via CORE_APB_ARB_TIMEOUT_EN
module core_apb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 34,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_psel,
  input  logic [NUM_MASTERS-1:0]          m_penable,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_paddr,
  input  logic [NUM_MASTERS-1:0]          m_pwrite,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_pwdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_pwstrb,
  output logic [NUM_MASTERS-1:0]          m_pready,
  output logic [DATA_W-1:0]               m_prdata,
  output logic [NUM_MASTERS-1:0]          m_pslverr,
  output logic                            s_psel,
  output logic                            s_penable,
  output logic                            s_pwrite,
  output logic [ADDR_W-1:0]               s_paddr,
  output logic [DATA_W-1:0]               s_pwdata,
  output logic [DATA_W/8-1:0]             s_pwstrb,
  input  logic                            s_pready,
  input  logic                            s_pslverr,
  input  logic [DATA_W-1:0]               s_prdata,
  output logic [2:0]                      grant_id,
  output logic                            busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                drop_q, drop_d;

  logic                any_req;
  logic [IDX_W-1:0]    winner;
  int                  best_off;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_write;
  logic [DATA_W-1:0]   win_wdata;
  logic [STRB_W-1:0]   win_wstrb;

  logic                grant_psel;
  logic                deliver;
  logic                xfer_done;
  logic                timeout_hit;
  logic                resp_err;
  logic                unused_inputs;

  // Distance of master idx from the round-robin search start (last+1); smaller wins.
  function automatic int rr_offset(input int idx, input logic [IDX_W-1:0] last);
    return (idx + NUM_MASTERS - 1 - int'(last)) % NUM_MASTERS;
  endfunction

  // Round-robin pick among requesting masters, capturing the winner's request fields.
  always_comb begin
    any_req   = 1'b0;
    winner    = '0;
    best_off  = NUM_MASTERS;
    win_addr  = '0;
    win_write = 1'b0;
    win_wdata = '0;
    win_wstrb = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (m_psel[i] && (rr_offset(i, last_grant_q) < best_off)) begin
        any_req   = 1'b1;
        best_off  = rr_offset(i, last_grant_q);
        winner    = i[IDX_W-1:0];
        win_addr  = m_paddr[i*ADDR_W +: ADDR_W];
        win_write = m_pwrite[i];
        win_wdata = m_pwdata[i*DATA_W +: DATA_W];
        win_wstrb = m_pwstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Current psel of the granted master, used to detect an abandoned request.
  always_comb begin
    grant_psel = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == i[IDX_W-1:0]) begin
        grant_psel = m_psel[i];
      end
    end
  end

`ifdef CORE_APB_ARB_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;

  // Watchdog counts ACCESS cycles already spent; zero outside ACCESS.
  always_comb begin
    wd_d = '0;
    if (state_q == ST_ACCESS) begin
      wd_d = wd_q + 16'd1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle only if the slave is still stalling.
  assign timeout_hit   = (state_q == ST_ACCESS) && !s_pready &&
                         (wd_q == 16'(TIMEOUT_CYCLES - 1));
  assign unused_inputs = ^m_penable;
`else
  assign timeout_hit   = 1'b0;
  assign unused_inputs = ^{m_penable, 16'(TIMEOUT_CYCLES)};
`endif

  // A real slave response always wins over a coincident timeout.
  assign xfer_done = (state_q == ST_ACCESS) && (s_pready || timeout_hit);
  assign resp_err  = s_pready ? s_pslverr : 1'b1;
  // Once the owner drops psel the response is swallowed, even if psel comes back.
  assign deliver   = !drop_q && grant_psel;

  // FSM next-state, grant capture and request latching.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    drop_d       = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (any_req) begin
          state_d = ST_SETUP;
          grant_d = winner;
          addr_d  = win_addr;
          write_d = win_write;
          wdata_d = win_wdata;
          wstrb_d = win_wstrb;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        drop_d  = drop_q || !grant_psel;
      end
      ST_ACCESS: begin
        drop_d = drop_q || !grant_psel;
        if (xfer_done) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transfer registers; reset points the search so master 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      drop_q       <= drop_d;
    end
  end

  // Route completion and error to the granted master only.
  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (xfer_done && deliver && !rst && (grant_q == i[IDX_W-1:0])) begin
        m_pready[i]  = 1'b1;
        m_pslverr[i] = resp_err;
      end
    end
  end

  assign s_psel    = (state_q != ST_IDLE) && !rst;
  assign s_penable = (state_q == ST_ACCESS) && !rst;
  assign busy      = s_psel;
  assign s_paddr   = addr_q;
  assign s_pwrite  = write_q;
  assign s_pwdata  = wdata_q;
  assign s_pwstrb  = wstrb_q;
  assign grant_id  = grant_q;
  assign m_prdata  = timeout_hit ? '0 : s_prdata;

endmodule

// File: tb/tb_core_apb_arbiter.sv
// tb/tb_core_apb_arbiter.sv - directed and randomized bench for core_apb_arbiter
module tb_core_apb_arbiter;
  localparam int NM = 4;
  localparam int AW = 34;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NM-1:0]     m_psel = '0;
  logic [NM-1:0]     m_penable = '0;
  logic [NM*AW-1:0]  m_paddr = '0;
  logic [NM-1:0]     m_pwrite = '0;
  logic [NM*DW-1:0]  m_pwdata = '0;
  logic [NM*SW-1:0]  m_pwstrb = '0;
  logic [NM-1:0]     m_pready;
  logic [DW-1:0]     m_prdata;
  logic [NM-1:0]     m_pslverr;
  logic              s_psel, s_penable, s_pwrite;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic [SW-1:0]     s_pwstrb;
  logic              s_pready = 1'b0;
  logic              s_pslverr = 1'b0;
  logic [DW-1:0]     s_prdata = '0;
  logic [2:0]        grant_id;
  logic              busy;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] ma  [NM];
  logic [DW-1:0] mwd [NM];
  logic [SW-1:0] mws [NM];
  logic          mw  [NM];
  logic [NM-1:0] pending;
  int            last_g;

  core_apb_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb), .m_pready(m_pready), .m_prdata(m_prdata),
    .m_pslverr(m_pslverr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb), .s_pready(s_pready),
    .s_pslverr(s_pslverr), .s_prdata(s_prdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first requester after the last served master.
  function automatic int pick(input logic [NM-1:0] req, input int last);
    int c;
    int r;
    r = int'(req);
    for (int k = 1; k <= NM; k++) begin
      c = (last + k) % NM;
      if (((r >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  task automatic randomize_master(input int i);
    ma[i]  = AW'({$urandom(), $urandom()});
    mwd[i] = $urandom();
    mws[i] = SW'($urandom());
    mw[i]  = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic [NM-1:0] sel);
    m_psel = sel;
    for (int i = 0; i < NM; i++) begin
      m_paddr[i*AW +: AW]  = ma[i];
      m_pwdata[i*DW +: DW] = mwd[i];
      m_pwstrb[i*SW +: SW] = mws[i];
      m_pwrite[i]          = mw[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pending = '0;
    drive('0);
    m_penable = '0;
    s_pready = 1'b0;
    s_pslverr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_g = NM - 1;
  endtask

  // One full arbitrated transfer; entered and left just after a rising edge with the DUT idle.
  task automatic run_xfer(input logic [NM-1:0] add_req, input int ws, input logic err,
                          input logic [DW-1:0] rdata);
    int g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic ew;
    pending = pending | add_req;
    drive(pending);
    g  = pick(pending, last_g);
    ea = ma[g]; ed = mwd[g]; es = mws[g]; ew = mw[g];
    @(negedge clk);
    check("idle_psel", s_psel, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("setup_psel", s_psel, 1);
    check("setup_penable", s_penable, 0);
    check("grant_id", grant_id, g);
    check("s_paddr", s_paddr, ea);
    check("s_pwrite", s_pwrite, ew);
    check("s_pwdata", s_pwdata, ed);
    check("s_pwstrb", s_pwstrb, es);
    check("setup_pready", m_pready, 0);
    @(posedge clk); #1;
    m_penable = NM'(1) << g;
    for (int w = 0; w < ws; w++) begin
      drive(pending ^ (NM'($urandom()) & ~(NM'(1) << g)));
      @(negedge clk);
      check("wait_penable", s_penable, 1);
      check("wait_pready", m_pready, 0);
      @(posedge clk); #1;
    end
    drive(pending);
    s_pready = 1'b1;
    s_pslverr = err;
    s_prdata = rdata;
    @(negedge clk);
    check("done_pready", m_pready, NM'(1) << g);
    check("done_pslverr", m_pslverr, err ? (NM'(1) << g) : NM'(0));
    check("done_prdata", m_prdata, rdata);
    check("hold_paddr", s_paddr, ea);
    check("hold_pwdata", s_pwdata, ed);
    @(posedge clk); #1;
    s_pready = 1'b0;
    s_pslverr = 1'b0;
    m_penable = '0;
    pending = pending & ~(NM'(1) << g);
    drive(pending);
    last_g = g;
  endtask

  initial begin
    int stuck;
    logic [NM-1:0] add;
    pending = '0;
    last_g = NM - 1;
    for (int i = 0; i < NM; i++) randomize_master(i);
    drive('0);

    // Reset state, including requests raised while reset is held.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_psel", s_psel, 0);
    check("rst_penable", s_penable, 0);
    check("rst_busy", busy, 0);
    check("rst_pready", m_pready, 0);
    check("rst_pslverr", m_pslverr, 0);
    check("rst_grant", grant_id, 0);
    check("rst_paddr", s_paddr, 0);
    check("rst_pwdata", s_pwdata, 0);
    check("rst_pwstrb", s_pwstrb, 0);
    drive('1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_hold_psel", s_psel, 0);
    check("rst_hold_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive('0);

    // Single read with two wait states.
    ma[0] = 34'h0_1000_0000;
    mw[0] = 1'b0;
    run_xfer(4'b0001, 2, 1'b0, 32'hDEADBEEF);

    // Contention after reset: 0,1,0,1.
    do_reset();
    run_xfer(4'b0011, 1, 1'b0, $urandom());
    run_xfer(4'b0001, 0, 1'b0, $urandom());
    run_xfer(4'b0010, 2, 1'b0, $urandom());
    run_xfer(4'b0000, 0, 1'b0, $urandom());

    // last_grant=1 with masters 1 and 3 requesting.
    do_reset();
    run_xfer(4'b0001, 0, 1'b0, $urandom());
    run_xfer(4'b0010, 0, 1'b0, $urandom());
    mwd[3] = 32'hA5A5A5A5;
    mws[3] = 4'h3;
    mw[3]  = 1'b1;
    run_xfer(4'b1010, 1, 1'b0, $urandom());
    run_xfer(4'b0000, 0, 1'b0, $urandom());

    // Slave error.
    run_xfer(4'b0100, 1, 1'b1, $urandom());

    // Granted master abandons during ACCESS: transfer completes, response discarded.
    drive(4'b0100);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_grant", grant_id, 2);
    @(posedge clk); #1;
    drive(4'b0000);
    @(negedge clk);
    check("drop_penable", s_penable, 1);
    @(posedge clk); #1;
    drive(4'b0100);
    s_pready = 1'b1;
    @(negedge clk);
    check("drop_pready", m_pready, 0);
    check("drop_pslverr", m_pslverr, 0);
    @(posedge clk); #1;
    s_pready = 1'b0;
    drive(4'b0000);
    @(negedge clk);
    check("drop_idle", s_psel, 0);
    @(posedge clk); #1;
    last_g = 2;
    run_xfer(4'b1001, 0, 1'b0, $urandom());
    run_xfer(4'b0000, 1, 1'b0, $urandom());

    // Reset during ACCESS with slave stalled.
    drive(4'b0010);
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_in_access", s_penable, 1);
    rst = 1'b1;
    drive('0);
    @(negedge clk);
    check("abort_rst_pready", m_pready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_psel", s_psel, 0);
    check("abort_busy", busy, 0);
    check("abort_pready", m_pready, 0);
    check("abort_grant", grant_id, 0);
    @(posedge clk); #1;
    pending = '0;
    last_g = NM - 1;
    run_xfer(4'b0011, 0, 1'b0, $urandom());
    run_xfer(4'b0000, 0, 1'b0, $urandom());

    // Slave stuck low.
    drive(4'b0100);
    s_prdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef CORE_APB_ARB_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      @(negedge clk);
      check("to_wait_pready", m_pready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_pready", m_pready, 4'b0100);
    check("to_pslverr", m_pslverr, 4'b0100);
    check("to_prdata", m_prdata, 0);
    @(posedge clk); #1;
    drive('0);
    @(negedge clk);
    check("to_idle", s_psel, 0);
    @(posedge clk); #1;
`else
    stuck = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (!(s_penable === 1'b1 && m_pready === '0)) stuck++;
      @(posedge clk); #1;
    end
    check("no_to_stuck", stuck, 0);
    s_pready = 1'b1;
    @(negedge clk);
    check("no_to_late_pready", m_pready, 4'b0100);
    check("no_to_late_prdata", m_prdata, 32'h12345678);
    @(posedge clk); #1;
    s_pready = 1'b0;
    drive('0);
`endif
    last_g = 2;

    // Randomized traffic against the reference round-robin.
    for (int n = 0; n < 40; n++) begin
      add = NM'($urandom());
      if ((pending | add) == '0) add = NM'(1) << $urandom_range(0, NM - 1);
      for (int i = 0; i < NM; i++) begin
        if (add[i] && !pending[i]) randomize_master(i);
      end
      run_xfer(add, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom());
    end
    for (int n = 0; n < NM; n++) begin
      if (pending != '0) run_xfer('0, 0, 1'b0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
